// File: rtl/sseg_display_arbiter_if.sv
// Bundles the requester-side and display-side signals of the seven-segment
// display arbiter.
//   master : pattern generators (drive req/pat0..2, observe grant/switch_p)
//   slave  : the arbiter (drives grant, in0..in3, switch_p)
interface sseg_display_arbiter_if;
  logic [2:0]  req;
  logic [31:0] pat0;
  logic [31:0] pat1;
  logic [31:0] pat2;
  logic [2:0]  grant;
  logic [7:0]  in0;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [7:0]  in3;
  logic        switch_p;

  modport master (
    output req, pat0, pat1, pat2,
    input  grant, in0, in1, in2, in3, switch_p
  );

  modport slave (
    input  req, pat0, pat1, pat2,
    output grant, in0, in1, in2, in3, switch_p
  );
endinterface

// File: rtl/sseg_display_arbiter.sv
// Round-robin owner selection for the 4-digit seven-segment display.
// Three requesters each offer a 32-bit pattern (byte K = digit K). The owner
// keeps the display for at least DWELL cycles unless it releases early; the
// owner's pattern is registered onto in0..in3 each cycle, BLANK when idle.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high
//   bus      : slave side of sseg_display_arbiter_if
//              (req, pat0..2 in; grant, in0..in3, switch_p out)
//
// state | meaning
// IDLE  | nobody owns the display, grant = 0, digits blanked
// OWN   | requester 'owner' holds the display, grant one-hot
module sseg_display_arbiter #(
  parameter int unsigned DWELL = 50_000_000,
  parameter logic [7:0]  BLANK = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  sseg_display_arbiter_if.slave bus
);

  localparam int unsigned CW = $clog2(DWELL);
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state_q, state_n;
  logic [1:0]    owner_q, owner_n;
  logic [1:0]    last_q, last_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    grant_q, grant_n;
  logic [2:0]    pick_any, pick_oth;
  logic [2:0]    others;
  logic [31:0]   sel_pat;

  function automatic logic [1:0] next3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Returns {found, index}; search order p+1, p+2, p (mod 3).
  function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
    logic [1:0] c1, c2;
    c1 = next3(p);
    c2 = next3(c1);
    if (r[c1])     return {1'b1, c1};
    else if (r[c2]) return {1'b1, c2};
    else if (r[p])  return {1'b1, p};
    else            return 3'b000;
  endfunction

  // Masking out the owner lets one search cover both the early-release and
  // the dwell-expired cases: the owner itself can never win.
  assign others   = bus.req & ~(3'b001 << owner_q);
  assign pick_any = rr_pick(last_q, bus.req);
  assign pick_oth = rr_pick(owner_q, others);

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any[2]) begin
          state_n = OWN;
          owner_n = pick_any[1:0];
          last_n  = pick_any[1:0];
          cnt_n   = '0;
        end
      end
      OWN: begin
        if (!bus.req[owner_q]) begin
          cnt_n = '0;
          if (pick_oth[2]) begin
            owner_n = pick_oth[1:0];
            last_n  = pick_oth[1:0];
          end else begin
            state_n = IDLE;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_n = cnt_q + 1'b1;
        end else if (pick_oth[2]) begin
          owner_n = pick_oth[1:0];
          last_n  = pick_oth[1:0];
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    grant_n = (state_n == OWN) ? (3'b001 << owner_n) : 3'b000;
  end

  always_comb begin
    sel_pat = bus.pat0;
    case (owner_q)
      2'd1:    sel_pat = bus.pat1;
      2'd2:    sel_pat = bus.pat2;
      default: sel_pat = bus.pat0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 2'd0;
      last_q       <= 2'd2;
      cnt_q        <= '0;
      grant_q      <= 3'b000;
      bus.switch_p <= 1'b0;
    end else begin
      state_q      <= state_n;
      owner_q      <= owner_n;
      last_q       <= last_n;
      cnt_q        <= cnt_n;
      grant_q      <= grant_n;
      bus.switch_p <= (grant_n != grant_q);
    end
  end

  // Display follows the current (registered) owner, so it lags grant by one
  // cycle but tracks live pattern changes.
  always_ff @(posedge clk) begin
    if (reset || state_q != OWN) begin
      bus.in0 <= BLANK;
      bus.in1 <= BLANK;
      bus.in2 <= BLANK;
      bus.in3 <= BLANK;
    end else begin
      bus.in0 <= sel_pat[7:0];
      bus.in1 <= sel_pat[15:8];
      bus.in2 <= sel_pat[23:16];
      bus.in3 <= sel_pat[31:24];
    end
  end

  assign bus.grant = grant_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
module tb_sseg_display_arbiter;

  localparam logic [31:0] P0 = 32'h11223344;
  localparam logic [31:0] P1 = 32'h55667788;
  localparam logic [31:0] P2 = 32'h99AABBCC;
  localparam logic [31:0] BL = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  sseg_display_arbiter_if bus();

  sseg_display_arbiter #(.DWELL(4), .BLANK(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  grant;
    logic        sp;
    logic [31:0] disp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [2:0] q, logic [2:0] g, logic s, logic [31:0] d);
    vec_t v;
    v.rst = r; v.req = q; v.grant = g; v.sp = s; v.disp = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] q);
    reset   = r;
    bus.req = q;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] disp();
    return {bus.in3, bus.in2, bus.in1, bus.in0};
  endfunction

  initial begin
    bus.req  = 3'b000;
    bus.pat0 = P0;
    bus.pat1 = P1;
    bus.pat2 = P2;

    // idle after reset
    tbl.push_back(mk(1, 3'b000, 3'b000, 0, BL));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 3'b000, 3'b000, 0, BL));
    // single requester 0, then release
    tbl.push_back(mk(0, 3'b001, 3'b001, 1, BL));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 3'b001, 3'b001, 0, P0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 1, P0));
    tbl.push_back(mk(0, 3'b000, 3'b000, 0, BL));
    // full contention from reset: each owner holds exactly 4 cycles
    tbl.push_back(mk(1, 3'b111, 3'b000, 0, BL));
    tbl.push_back(mk(0, 3'b111, 3'b001, 1, BL));
    tbl.push_back(mk(0, 3'b111, 3'b001, 0, P0));
    tbl.push_back(mk(0, 3'b111, 3'b001, 0, P0));
    tbl.push_back(mk(0, 3'b111, 3'b001, 0, P0));
    tbl.push_back(mk(0, 3'b111, 3'b010, 1, P0));
    tbl.push_back(mk(0, 3'b111, 3'b010, 0, P1));
    tbl.push_back(mk(0, 3'b111, 3'b010, 0, P1));
    tbl.push_back(mk(0, 3'b111, 3'b010, 0, P1));
    tbl.push_back(mk(0, 3'b111, 3'b100, 1, P1));
    tbl.push_back(mk(0, 3'b111, 3'b100, 0, P2));
    tbl.push_back(mk(0, 3'b111, 3'b100, 0, P2));
    tbl.push_back(mk(0, 3'b111, 3'b100, 0, P2));
    tbl.push_back(mk(0, 3'b111, 3'b001, 1, P2));
    tbl.push_back(mk(0, 3'b111, 3'b001, 0, P0));
    // reset while owning, then restart at requester 0
    tbl.push_back(mk(1, 3'b111, 3'b000, 0, BL));
    tbl.push_back(mk(0, 3'b111, 3'b001, 1, BL));
    tbl.push_back(mk(0, 3'b111, 3'b001, 0, P0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].req);
      chk($sformatf("vec%0d grant", i), 32'(bus.grant), 32'(tbl[i].grant));
      chk($sformatf("vec%0d switch_p", i), 32'(bus.switch_p), 32'(tbl[i].sp));
      chk($sformatf("vec%0d disp", i), disp(), tbl[i].disp);
    end

    // live pattern update
    step(1, 3'b000);
    step(0, 3'b001);
    step(0, 3'b001);
    chk("live before", disp(), P0);
    bus.pat0 = 32'h0;
    step(0, 3'b001);
    chk("live after", disp(), 32'h0);
    bus.pat0 = P0;

    // early release hands over directly, dwell restarts
    step(1, 3'b000);
    step(0, 3'b011);
    chk("early g0", 32'(bus.grant), 32'h1);
    step(0, 3'b011);
    step(0, 3'b010);
    chk("early handover", 32'(bus.grant), 32'h2);
    chk("early sp", 32'(bus.switch_p), 32'h1);
    for (int i = 0; i < 3; i++) begin
      step(0, 3'b011);
      chk($sformatf("early hold%0d", i), 32'(bus.grant), 32'h2);
    end
    step(0, 3'b011);
    chk("early dwell end", 32'(bus.grant), 32'h1);

    // saturated owner serves late request at once, then release to idle
    step(1, 3'b000);
    for (int i = 0; i < 10; i++) step(0, 3'b010);
    chk("sat owner", 32'(bus.grant), 32'h2);
    chk("sat disp", disp(), P1);
    step(0, 3'b110);
    chk("sat switch", 32'(bus.grant), 32'h4);
    chk("sat sp", 32'(bus.switch_p), 32'h1);
    step(0, 3'b000);
    chk("release grant", 32'(bus.grant), 32'h0);
    chk("release sp", 32'(bus.switch_p), 32'h1);
    step(0, 3'b000);
    chk("release disp", disp(), BL);
    chk("release sp off", 32'(bus.switch_p), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_display_arbiter.md
# sseg_display_arbiter

Time-shares the 4-digit seven-segment display among three pattern requesters (e.g. rotating-square, heart-beat and counter generators). Each requester presents a 32-bit, four-digit segment pattern plus a level request. The arbiter grants the display round-robin with a minimum dwell per grant, and drives the four digit inputs of `disp_mux`. It sits between the pattern generators and `disp_mux`, and replaces the hard-wired `ledN` connections.

## Interface
- `DWELL`, default 50_000_000: minimum clock cycles a grant is held before another requester may take over; legal range ≥ 2.
- `BLANK`, default 8'hFF: per-digit pattern driven when no one owns the display (active-low segments, all off).

Ports:
- `clk`  in  1: system clock; one clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  3: level request, bit k for requester k.
- `pat0`, `pat1`, `pat2`  in  32 each: requester pattern, [7:0] = digit 0 … [31:24] = digit 3.
- `grant`  out  3: one-hot current owner; 3'b000 when idle.
- `in0`, `in1`, `in2`, `in3`  out  8 each: digit patterns to `disp_mux` `in0..in3`.
- `switch_p`  out  1: one-cycle pulse on every cycle in which `grant` changes value.

## Operation
- The FSM has two states.
  - IDLE: `grant`=0.
  - OWN: exactly one `grant` bit set.
- Registers:
  - `owner` (2 bit): values 0..2.
  - `last` (2 bit): round-robin pointer, the last granted requester.
  - `cnt`: dwell counter, width $clog2(DWELL).
- Round-robin search order from pointer p: p+1, p+2, p (mod 3). The first asserted `req` in that order wins.
- IDLE:
  - If any `req` is high, grant the winner of the search from `last`.
  - Then go to OWN, set `last`=`owner`=winner, `cnt`=0.
- OWN, when the owner's `req` is low (at any `cnt`, early release allowed):
  - If another `req` is high, hand over directly to the search winner, with no idle cycle, and set `cnt`=0.
  - Otherwise go to IDLE.
- OWN, when the owner's `req` is high and `cnt` < DWELL-1: increment `cnt`. No switch occurs.
- OWN, when the owner's `req` is high and `cnt` == DWELL-1:
  - If another `req` is high (search order owner+1, owner+2), switch to it and set `cnt`=0.
  - Otherwise stay, with `cnt` saturated at DWELL-1, so a later request is served on the next edge.
- No preemption before the dwell expires, except through the owner's own release.
- Display path: `inK` is registered every cycle.
  - In OWN: `inK` ← byte K of the owner's `pat`.
  - In IDLE: `inK` ← BLANK.
  - The pattern is live: changes on the owner's `pat` propagate without waiting for a switch.
- `switch_p` is registered and is high for the one cycle following any `grant` change. This covers IDLE→OWN, OWN→OWN(other) and OWN→IDLE.

## Timing
- Reset values:
  - `grant`=0, `switch_p`=0, `in0..in3`=BLANK.
  - FSM=IDLE, `cnt`=0.
  - `last`=2, so the first arbitration order is 0, 1, 2.
- `reset` dominates all other inputs on the same edge. A reset during OWN blanks the display on the next edge.
- Request → `grant`: 1 cycle (a `req` sampled at edge n makes `grant` valid after edge n).
- `grant` → display: 1 cycle (`inK` shows the new owner's pattern one edge after `grant` changes).
- Request → display: 2 cycles.
- With continuous contention, each owner holds exactly DWELL cycles. The grant changes on the edge where `cnt`==DWELL-1 is sampled.
- Simultaneous owner release and another request: direct handover, `grant` never 0.
- `grant` is always one-hot or zero. `cnt` never exceeds DWELL-1.

## Test plan
Use DWELL=4, pat0=32'h11223344, pat1=32'h55667788, pat2=32'h99AABBCC.
1. Reset, `req`=0 for 10 cycles → `grant`=000, `in0..in3`=FF, `switch_p`=0 throughout.
2. `req`=001 from cycle 0 → `grant`=001 after edge 1, `switch_p`=1 for one cycle, `in0`=44 `in1`=33 `in2`=22 `in3`=11 after edge 2. Changing pat0 to 32'h0 appears on `in*` one cycle later.
3. `req`=111 from reset, held → `grant` sequence 001, 010, 100, 001, each held exactly 4 cycles, `switch_p` pulses every 4 cycles.
4. `req`=011 with owner 0. Drop `req[0]` at `cnt`=1 → `grant`=010 on the next edge (no 000 cycle), `cnt` restarts at 0.
5. Owner 1 alone for 10 cycles (`cnt` saturated at 3), then raise `req[2]` → `grant`=100 on the following edge. Then drop all requests → `grant`=000 and `in*`=FF one cycle later.
6. Assert `reset` during OWN with `req`=111 → `grant`=000 and `in*`=FF after that edge. On release, the first grant goes to requester 0.
